// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage requester for the multi-cycle divider; issues DIV/DIVU, stalls until ready, presents HI/LO write
//   clk, rst                 clock, synchronous active-high reset
//   aluop_i, reg1_i, reg2_i  EX instruction opcode and operands (rs dividend, rt divisor)
//   flush_i, ex_stall_i      pipeline flush, external EX hold
//   div_result_i, div_ready_i  divider result {rem, quot} and valid
//   div_opdata1_o/2_o, div_signed_o, div_start_o, div_annul_o  divider request
//   stallreq_o               pipeline stall request
//   whilo_o, hi_o, lo_o      HI/LO write (hi = remainder, lo = quotient)
module div_issue_ctrl #(
   parameter logic [7:0] DIV_OP  = 8'b00011010,
   parameter logic [7:0] DIVU_OP = 8'b00011011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic        flush_i,
   input  logic        ex_stall_i,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic [31:0] div_opdata1_o,
   output logic [31:0] div_opdata2_o,
   output logic        div_signed_o,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        stallreq_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);
   typedef enum logic [1:0] {IDLE, BUSY, HOLD, GAP} state_t;
   state_t state, next;
   logic [31:0] op1_q, op2_q, hi_q, lo_q;
   logic signed_q, is_div, issue;
   assign is_div = (aluop_i == DIV_OP) | (aluop_i == DIVU_OP);
   assign issue = is_div & ~flush_i;
   always_comb begin
      next = state;
      div_start_o = 1'b0;
      stallreq_o = 1'b0;
      whilo_o = 1'b0;
      div_annul_o = flush_i;
      div_opdata1_o = op1_q;
      div_opdata2_o = op2_q;
      div_signed_o = signed_q;
      hi_o = hi_q;
      lo_o = lo_q;
      case (state)
         IDLE: begin
            div_opdata1_o = reg1_i;
            div_opdata2_o = reg2_i;
            div_signed_o = aluop_i == DIV_OP;
            div_start_o = issue;
            stallreq_o = issue;
            next = issue ? BUSY : IDLE;
         end
         BUSY: begin
            div_start_o = ~flush_i & ~div_ready_i;
            stallreq_o = ~flush_i & ~div_ready_i;
            whilo_o = ~flush_i & div_ready_i;
            hi_o = whilo_o ? div_result_i[63:32] : hi_q;
            lo_o = whilo_o ? div_result_i[31:0] : lo_q;
            next = flush_i ? GAP : ~div_ready_i ? BUSY : ex_stall_i ? HOLD : GAP;
         end
         HOLD: begin
            whilo_o = ~flush_i;
            next = (ex_stall_i & ~flush_i) ? HOLD : GAP;
         end
         default: begin
            // the next divide waits one cycle so the divider is back to its free state
            stallreq_o = is_div;
            next = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op1_q <= '0;
         op2_q <= '0;
         signed_q <= 1'b0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         state <= next;
         if (state == IDLE && issue) begin
            op1_q <= reg1_i;
            op2_q <= reg2_i;
            signed_q <= aluop_i == DIV_OP;
         end
         if (state == BUSY && ~flush_i && div_ready_i) begin
            hi_q <= div_result_i[63:32];
            lo_q <= div_result_i[31:0];
         end
      end
   end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed and randomized divides against a behavioural divide model
module tb_div_issue_ctrl;
   localparam logic [7:0] DIV = 8'b00011010, DIVU = 8'b00011011;
   logic clk = 0, rst = 1, flush_i = 0, ex_stall_i = 0, div_ready_i = 0;
   logic [7:0] aluop_i = 0;
   logic [31:0] reg1_i = 0, reg2_i = 0;
   logic [63:0] div_result_i = 0;
   logic [31:0] div_opdata1_o, div_opdata2_o, hi_o, lo_o;
   logic div_signed_o, div_start_o, div_annul_o, stallreq_o, whilo_o;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   div_issue_ctrl dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .flush_i(flush_i), .ex_stall_i(ex_stall_i), .div_result_i(div_result_i),
      .div_ready_i(div_ready_i), .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
      .div_signed_o(div_signed_o), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
      .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input bit u, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return 64'd0;
      if (u) return {a % b, a / b};
      return {32'(sa % sb), 32'(sa / sb)};
   endfunction

   function automatic bit is_div_op(input logic [7:0] op);
      return op == DIV || op == DIVU;
   endfunction

   // one instruction issued, lat cycles to ready, hold HOLD cycles, then the GAP cycle with nxt in EX
   task automatic run_div(input bit u, input logic [31:0] a, input logic [31:0] b, input int lat,
                          input int hold, input bit chg, input logic [7:0] nxt);
      logic [63:0] res;
      res = ref_div(u, a, b);
      aluop_i = u ? DIVU : DIV; reg1_i = a; reg2_i = b;
      flush_i = 0; ex_stall_i = 0; div_ready_i = 0;
      #1;
      chk("issue_start", div_start_o, 1);
      chk("issue_stall", stallreq_o, 1);
      chk("issue_op", {div_opdata1_o, div_opdata2_o}, {a, b});
      chk("issue_signed", div_signed_o, !u);
      chk("issue_whilo", whilo_o, 0);
      tick();
      for (int i = 1; i < lat; i++) begin
         if (chg) begin reg1_i = $urandom; reg2_i = $urandom; end
         #1;
         chk("busy_start_stall", {div_start_o, stallreq_o, whilo_o}, 3'b110);
         chk("busy_op", {div_opdata1_o, div_opdata2_o, 31'd0, div_signed_o}, {a, b, 31'd0, !u});
         tick();
      end
      div_ready_i = 1; div_result_i = res; ex_stall_i = hold > 0;
      #1;
      chk("ready_ctl", {div_start_o, stallreq_o, whilo_o}, 3'b001);
      chk("ready_hilo", {hi_o, lo_o}, res);
      tick();
      div_ready_i = 0; div_result_i = ~res;
      for (int i = 0; i < hold; i++) begin
         ex_stall_i = i < hold - 1;
         #1;
         chk("hold_ctl", {div_start_o, stallreq_o, whilo_o}, 3'b001);
         chk("hold_hilo", {hi_o, lo_o}, res);
         tick();
      end
      ex_stall_i = 0; aluop_i = nxt; reg1_i = $urandom; reg2_i = $urandom;
      #1;
      chk("gap_ctl", {div_start_o, whilo_o, stallreq_o}, {2'b00, is_div_op(nxt)});
      chk("gap_hilo", {hi_o, lo_o}, res);
      tick();
   endtask

   // issue then flush after busy_n BUSY cycles, optionally colliding with ready
   task automatic flush_div(input bit u, input logic [31:0] a, input logic [31:0] b,
                            input int busy_n, input bit rdy);
      aluop_i = u ? DIVU : DIV; reg1_i = a; reg2_i = b; div_ready_i = 0;
      #1;
      chk("fl_issue", div_start_o, 1);
      tick();
      for (int i = 0; i < busy_n; i++) begin
         #1;
         chk("fl_busy", {div_start_o, stallreq_o}, 2'b11);
         tick();
      end
      flush_i = 1; div_ready_i = rdy; div_result_i = ref_div(u, a, b);
      #1;
      chk("fl_ctl", {div_annul_o, div_start_o, stallreq_o, whilo_o}, 4'b1000);
      tick();
      flush_i = 0; div_ready_i = 0; aluop_i = DIVU;
      #1;
      chk("fl_gap", {div_annul_o, div_start_o, whilo_o, stallreq_o}, 4'b0001);
      tick();
   endtask

   initial begin
      logic [31:0] a, b;
      bit u;
      rst = 1;
      tick();
      tick();
      #1;
      chk("rst_ctl", {div_start_o, stallreq_o, whilo_o, div_annul_o, div_signed_o}, 5'b0);
      chk("rst_hilo", {hi_o, lo_o}, 64'd0);
      chk("rst_op", {div_opdata1_o, div_opdata2_o}, 64'd0);
      rst = 0;
      aluop_i = 8'h21; reg1_i = 32'h1234; reg2_i = 32'h5678;
      tick();
      #1;
      chk("idle_ctl", {div_start_o, stallreq_o, whilo_o}, 3'b000);
      chk("idle_op", {div_opdata1_o, div_opdata2_o}, {32'h1234, 32'h5678});
      tick();
      run_div(0, 32'hFFFFFFF9, 32'd2, 35, 0, 0, 8'h00);
      run_div(1, 32'd100, 32'd7, 20, 0, 1, 8'h00);
      run_div(0, 32'd5, 32'd0, 3, 0, 0, 8'h00);
      flush_div(0, 32'd1000, 32'd3, 10, 0);
      run_div(1, 32'd9, 32'd4, 12, 0, 0, DIVU);
      run_div(1, 32'd77, 32'd10, 5, 0, 0, 8'h00);
      run_div(1, 32'hDEADBEEF, 32'd13, 8, 3, 0, 8'h00);
      flush_div(1, 32'd50, 32'd5, 4, 1);
      run_div(0, 32'd64, 32'hFFFFFFF8, 1, 1, 0, 8'h00);
      aluop_i = DIV; flush_i = 1;
      #1;
      chk("idle_flush", {div_annul_o, div_start_o, stallreq_o}, 3'b100);
      tick();
      flush_i = 0; aluop_i = 8'h00;
      #1;
      chk("idle_flush_noissue", {div_start_o, stallreq_o, div_annul_o}, 3'b000);
      tick();
      for (int n = 0; n < 8; n++) begin
         u = $urandom_range(0, 1);
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 1 << $urandom_range(1, 31));
         if (!u && b == 32'hFFFFFFFF) b = 32'd3;
         run_div(u, a, b, $urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(0, 1),
                 n == 7 ? 8'h00 : ($urandom_range(0, 1) ? DIV : DIVU));
      end
      aluop_i = DIVU; reg1_i = 32'd40; reg2_i = 32'd6;
      tick();
      tick();
      tick();
      rst = 1; aluop_i = 8'h00;
      tick();
      #1;
      chk("rst_mid_ctl", {div_start_o, stallreq_o, whilo_o}, 3'b000);
      chk("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
      rst = 0;
      tick();
      run_div(1, 32'd40, 32'd6, 6, 0, 0, 8'h00);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
